// File: rtl/rf_mul_master.sv
// rf_mul_master
//   Bus master and host mux that sits directly in front of the register
//   file's single slave port. In IDLE the host port passes through to the
//   register file combinationally. A host write of data bit0=1 to START_ADDR
//   launches an unsigned 32x32 multiply. The block reads operands A and B,
//   runs 32 shift-add iterations and writes the 64-bit product as two words.
//   It then writes 1 to the done register.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   h_wr       in   host write strobe
//   h_addr     in   host word address [15:0]
//   h_din      in   host write data [31:0]
//   h_dout     out  host read data [63:0], always equal to rf_dout
//   h_wait     out  host must hold its request while high (== busy)
//   rf_wr      out  register file write strobe
//   rf_addr    out  register file address [15:0]
//   rf_din     out  register file write data [31:0]
//   rf_dout    in   register file read data [63:0] (combinational read)
//   busy       out  operation in progress (any state other than IDLE)
//   done       out  one-cycle pulse while the done flag is being written
//   dbg_state  out  current FSM state encoding, for observation only
//
// Handshake: the host may issue a request only while h_wait=0. While
// h_wait=1, host writes are discarded and never reach the register file.
// Host reads return rf_dout at whatever address the block is driving.
module rf_mul_master #(
  parameter logic [15:0] START_ADDR  = 16'h0000,
  parameter logic [15:0] OPA_ADDR    = 16'h0002,
  parameter logic [15:0] OPB_ADDR    = 16'h0003,
  parameter logic [15:0] RES_LO_ADDR = 16'h0004,
  parameter logic [15:0] RES_HI_ADDR = 16'h0005,
  parameter logic [15:0] DONE_ADDR   = 16'h0015
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_wr,
  input  logic [15:0] h_addr,
  input  logic [31:0] h_din,
  output logic [63:0] h_dout,
  output logic        h_wait,
  output logic        rf_wr,
  output logic [15:0] rf_addr,
  output logic [31:0] rf_din,
  input  logic [63:0] rf_dout,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_A    = 3'd1,
    RD_B    = 3'd2,
    MUL     = 3'd3,
    WR_LO   = 3'd4,
    WR_HI   = 3'd5,
    WR_DONE = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [63:0] p_q, p_d;
  logic [32:0] sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    sum     = '0;
    rf_wr   = 1'b0;
    rf_addr = h_addr;
    rf_din  = '0;

    case (state_q)
      IDLE: begin
        rf_wr   = h_wr;
        rf_addr = h_addr;
        rf_din  = h_din;
        // The start write itself is forwarded so the RF sees it as well.
        if (h_wr && (h_addr == START_ADDR) && h_din[0]) begin
          state_d = RD_A;
        end
      end
      RD_A: begin
        rf_addr = OPA_ADDR;
        a_d     = rf_dout[31:0];
        state_d = RD_B;
      end
      RD_B: begin
        rf_addr = OPB_ADDR;
        // B sits in the low half; it is shifted out as the multiplier while
        // the partial product grows into the high half.
        p_d     = {32'b0, rf_dout[31:0]};
        cnt_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        rf_addr = OPB_ADDR;
        sum     = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_q} : 33'd0);
        p_d     = {sum, p_q[31:1]};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        rf_wr   = 1'b1;
        rf_addr = RES_LO_ADDR;
        rf_din  = p_q[31:0];
        state_d = WR_HI;
      end
      WR_HI: begin
        rf_wr   = 1'b1;
        rf_addr = RES_HI_ADDR;
        rf_din  = p_q[63:32];
        state_d = WR_DONE;
      end
      WR_DONE: begin
        rf_wr   = 1'b1;
        rf_addr = DONE_ADDR;
        rf_din  = 32'h1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign h_wait    = busy;
  assign done      = (state_q == WR_DONE);
  assign h_dout    = rf_dout;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_mul_master.sv
// tb_rf_mul_master
//   Bench for rf_mul_master. It holds a small register file model and a
//   reference model that computes the product with a plain 64-bit multiply.
//   The reference model also gives the expected cycle, address and data of
//   every register file write.
module tb_rf_mul_master;

  logic        clk;
  logic        reset;
  logic        h_wr;
  logic [15:0] h_addr;
  logic [31:0] h_din;
  logic [63:0] h_dout;
  logic        h_wait;
  logic        rf_wr;
  logic [15:0] rf_addr;
  logic [31:0] rf_din;
  logic [63:0] rf_dout;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  // Expected and observed RF writes: {cycle[15:0], addr[15:0], data[31:0]}
  logic [63:0] exp_q[$];
  logic [63:0] act_q[$];

  logic [31:0] rf_mem [0:63];

  rf_mul_master dut (
    .clk       (clk),
    .reset     (reset),
    .h_wr      (h_wr),
    .h_addr    (h_addr),
    .h_din     (h_din),
    .h_dout    (h_dout),
    .h_wait    (h_wait),
    .rf_wr     (rf_wr),
    .rf_addr   (rf_addr),
    .rf_din    (rf_din),
    .rf_dout   (rf_dout),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  assign rf_dout = {~rf_mem[rf_addr[5:0]], rf_mem[rf_addr[5:0]]};

  always @(posedge clk) begin
    if (rf_wr) rf_mem[rf_addr[5:0]] <= rf_din;
  end

  // ---------------- driver tasks ----------------
  task automatic host_write(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    h_wr = 1'b1; h_addr = addr; h_din = data;
    @(posedge clk);
  endtask

  task automatic host_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h_wr = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic issue_start();
    host_write(16'h0000, 32'h1);
  endtask

  // Assumes the start edge (edge 0) has just occurred. Steps cycles 1..38 and
  // checks status outputs and RF writes against the reference model.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input bit intrude, input bit chain, input bit ie);
    logic [63:0] prod;
    logic [63:0] e, o;
    logic [31:0] junk;
    prod = {32'b0, a} * {32'b0, b};
    junk = $urandom;
    exp_q.delete();
    act_q.delete();
    exp_q.push_back({16'd35, 16'h0004, prod[31:0]});
    exp_q.push_back({16'd36, 16'h0005, prod[63:32]});
    exp_q.push_back({16'd37, 16'h0015, 32'h1});
    if (chain) exp_q.push_back({16'd38, 16'h0000, 32'h1});

    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      h_wr = 1'b0;
      if (intrude && c == 10) begin
        h_wr = 1'b1; h_addr = 16'h0002; h_din = junk;
      end
      if (chain && c == 38) begin
        h_wr = 1'b1; h_addr = 16'h0000; h_din = 32'h1;
      end
      #1;
      checks++;
      if (busy !== (c <= 37)) begin
        errors++;
        $display("FAIL busy cycle %0d: got %b want %b", c, busy, (c <= 37));
      end
      checks++;
      if (h_wait !== (c <= 37)) begin
        errors++;
        $display("FAIL h_wait cycle %0d: got %b want %b", c, h_wait, (c <= 37));
      end
      checks++;
      if (done !== (c == 37)) begin
        errors++;
        $display("FAIL done cycle %0d: got %b want %b", c, done, (c == 37));
      end
      if (c == 1) begin
        checks++;
        if (h_dout[31:0] !== a) begin
          errors++;
          $display("FAIL opa_read: got %h want %h", h_dout[31:0], a);
        end
      end
      if (c == 2) begin
        checks++;
        if (h_dout[31:0] !== b) begin
          errors++;
          $display("FAIL opb_read: got %h want %h", h_dout[31:0], b);
        end
      end
      if (rf_wr === 1'b1) act_q.push_back({16'(c), rf_addr, rf_din});
    end

    // scoreboard
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wr_count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      o = act_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rf_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                 o[63:48], o[47:32], o[31:0], e[63:48], e[47:32], e[31:0]);
      end
    end
    checks++;
    if (rf_mem[2] !== a) begin
      errors++;
      $display("FAIL operand_a_kept: got %h want %h", rf_mem[2], a);
    end
    checks++;
    if ({rf_mem[5], rf_mem[4]} !== prod) begin
      errors++;
      $display("FAIL product: got %h want %h", {rf_mem[5], rf_mem[4]}, prod);
    end
    checks++;
    if ((rf_mem[21][0] & rf_mem[22][0]) !== ie) begin
      errors++;
      $display("FAIL interrupt_out: got %b want %b", rf_mem[21][0] & rf_mem[22][0], ie);
    end
    if (chain) @(posedge clk);
  endtask

  task automatic load_ops(input logic [31:0] a, input logic [31:0] b, input bit ie);
    host_write(16'h0002, a);
    host_write(16'h0003, b);
    host_write(16'h0015, 32'h0);
    host_write(16'h0016, {31'b0, ie});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    h_wr = 1'b1; h_addr = 16'h0030; h_din = 32'hCAFE_0001;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || h_wait !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b wait=%b want 0 0 0", busy, done, h_wait);
    end
    checks++;
    if (rf_wr !== 1'b1 || rf_addr !== 16'h0030 || rf_din !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL reset_passthru: got %b %h %h want 1 0030 cafe0001", rf_wr, rf_addr, rf_din);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    h_wr = 1'b0;
    reset = 1'b0;
    host_idle(2);
  endtask

  task automatic test_no_start();
    @(negedge clk);
    h_wr = 1'b1; h_addr = 16'h0000; h_din = 32'h0000_0002;
    #1;
    checks++;
    if (rf_wr !== 1'b1 || rf_addr !== 16'h0000 || rf_din !== 32'h2) begin
      errors++;
      $display("FAIL nostart_fwd: got %b %h %h want 1 0000 00000002", rf_wr, rf_addr, rf_din);
    end
    @(posedge clk);
    @(negedge clk);
    h_wr = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL nostart_busy: got %b want 0", busy);
    end
    checks++;
    if (rf_mem[0] !== 32'h2) begin
      errors++;
      $display("FAIL nostart_mem: got %h want 00000002", rf_mem[0]);
    end
    @(posedge clk);
  endtask

  task automatic test_basic();
    load_ops(32'd3, 32'd5, 1'b1);
    issue_start();
    run_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_max();
    load_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue_start();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero();
    load_ops(32'h0, 32'h1234_5678, 1'b0);
    issue_start();
    run_op(32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    load_ops(32'h0, 32'h1234_5678, 1'b1);
    issue_start();
    run_op(32'h0, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_busy_write();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    load_ops(a, b, 1'b1);
    issue_start();
    run_op(a, b, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    load_ops(a, b, 1'b1);
    issue_start();
    run_op(a, b, 1'b0, 1'b1, 1'b1);
    run_op(a, b, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit ie;
    for (int n = 0; n < 6; n++) begin
      a = $urandom;
      b = (n == 0) ? 32'h8000_0000 : $urandom;
      ie = 1'($urandom_range(0, 1));
      load_ops(a, b, ie);
      issue_start();
      run_op(a, b, 1'b0, 1'b0, ie);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s4, s5, s21;
    int stray;
    load_ops(32'h1111_2222, 32'h3333_4444, 1'b0);
    host_write(16'h0004, 32'hDEAD_0004);
    host_write(16'h0005, 32'hDEAD_0005);
    s4 = 32'hDEAD_0004; s5 = 32'hDEAD_0005; s21 = 32'h0;
    issue_start();
    stray = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      h_wr = 1'b0;
      #1;
      if (rf_wr === 1'b1) stray++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || h_wait !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_status: got busy=%b wait=%b done=%b want 0 0 0", busy, h_wait, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (rf_wr === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid_writes: got %0d want 0", stray);
    end
    checks++;
    if (rf_mem[4] !== s4 || rf_mem[5] !== s5 || rf_mem[21] !== s21) begin
      errors++;
      $display("FAIL reset_mid_mem: got %h %h %h want %h %h %h",
               rf_mem[4], rf_mem[5], rf_mem[21], s4, s5, s21);
    end
    @(posedge clk);
    load_ops(32'h1111_2222, 32'h3333_4444, 1'b1);
    issue_start();
    run_op(32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 64; i++) rf_mem[i] = 32'h0;
    reset = 1'b1; h_wr = 1'b0; h_addr = 16'h0; h_din = 32'h0;
    test_reset();
    test_no_start();
    test_basic();
    test_max();
    test_zero();
    test_busy_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
